// File: rtl/alu_issue_stage.sv
// -----------------------------------------------------------------------------
// alu_issue_stage
//
// Execute-stage front end of the 8-bit RISC pipeline. It drives the ALU and
// hands results to write-back.
//
//   S1 (ALU drive registers): ALU_A, ALU_B and CTRL_ALU, plus the opcode and
//       destination index that travel with them.
//   S2 (result registers): OUT_OP, OUT_DST, OUT_RES. The architectural FLAGS
//       register is also written when an arithmetic op moves from S1 to S2.
//
// Both stages use valid/ready flow control with full backpressure, so the
// stage can accept one instruction per cycle.
//
// Configuration macro:
//   FWD_EN  When defined, register operands are forwarded at S1 accept. The
//           S1 entry has priority, then the S2 entry. STORE is never treated
//           as a producer. When undefined, IN_A and IN_B are used verbatim,
//           and IN_SRC_A/B and IN_A/B_REG are ignored.
//
// Ports:
//   CLK, RST              clock, synchronous active-low reset
//   IN_VALID/IN_READY     instruction handshake
//                         (IN_READY is combinational from OUT_READY)
//   IN_OP, IN_DST         opcode and destination register index
//   IN_A, IN_B            operand values
//   IN_SRC_A/B            source register indices (forwarding only)
//   IN_A/B_REG            operand comes from a register (forwarding only)
//   ALU_A, ALU_B          registered ALU operands
//   CTRL_ALU              registered ALU control
//   ALU_S                 ALU result, combinational from ALU_A/ALU_B/CTRL_ALU
//   ALU_N/O/Z/C           ALU flags
//   OUT_VALID/OUT_READY   write-back handshake
//   OUT_OP, OUT_DST       opcode and destination of the retiring instruction
//   OUT_RES               result of the retiring instruction
//   FLAGS                 architectural flags {N,O,Z,C}
// -----------------------------------------------------------------------------
module alu_issue_stage #(
   parameter int DATA_W = 8,
   parameter int OP_W   = 8,
   parameter int REG_W  = 4
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              IN_VALID,
   output logic              IN_READY,
   input  logic [OP_W-1:0]   IN_OP,
   input  logic [REG_W-1:0]  IN_DST,
   input  logic [DATA_W-1:0] IN_A,
   input  logic [DATA_W-1:0] IN_B,
   input  logic [REG_W-1:0]  IN_SRC_A,
   input  logic [REG_W-1:0]  IN_SRC_B,
   input  logic              IN_A_REG,
   input  logic              IN_B_REG,
   output logic [DATA_W-1:0] ALU_A,
   output logic [DATA_W-1:0] ALU_B,
   output logic [2:0]        CTRL_ALU,
   input  logic [DATA_W-1:0] ALU_S,
   input  logic              ALU_N,
   input  logic              ALU_O,
   input  logic              ALU_Z,
   input  logic              ALU_C,
   output logic              OUT_VALID,
   input  logic              OUT_READY,
   output logic [OP_W-1:0]   OUT_OP,
   output logic [REG_W-1:0]  OUT_DST,
   output logic [DATA_W-1:0] OUT_RES,
   output logic [3:0]        FLAGS
);

   localparam logic [OP_W-1:0] OP_ADD = OP_W'(8'h01);
   localparam logic [OP_W-1:0] OP_MUL = OP_W'(8'h02);
   localparam logic [OP_W-1:0] OP_SOU = OP_W'(8'h03);
   localparam logic [OP_W-1:0] OP_DIV = OP_W'(8'h04);

   // Only the four arithmetic opcodes select an ALU operation. All other
   // opcodes map to 3'b000 and pass through, so CTRL_ALU != 0 marks arithmetic.
   function automatic logic [2:0] map_op(input logic [OP_W-1:0] op);
      logic [2:0] ctrl;
      case (op)
         OP_ADD:  ctrl = 3'b001;
         OP_MUL:  ctrl = 3'b010;
         OP_SOU:  ctrl = 3'b011;
         OP_DIV:  ctrl = 3'b100;
         default: ctrl = 3'b000;
      endcase
      return ctrl;
   endfunction

   // ---------------------------------------------------------------- state
   logic              s1_valid_q, s1_valid_d;
   logic [DATA_W-1:0] alu_a_q,    alu_a_d;
   logic [DATA_W-1:0] alu_b_q,    alu_b_d;
   logic [2:0]        ctrl_alu_q, ctrl_alu_d;
   logic [OP_W-1:0]   s1_op_q,    s1_op_d;
   logic [REG_W-1:0]  s1_dst_q,   s1_dst_d;

   logic              s2_valid_q, s2_valid_d;
   logic [OP_W-1:0]   out_op_q,   out_op_d;
   logic [REG_W-1:0]  out_dst_q,  out_dst_d;
   logic [DATA_W-1:0] out_res_q,  out_res_d;
   logic [3:0]        flags_q,    flags_d;

   // ---------------------------------------------------------------- control
   logic              s2_adv;
   logic              s1_adv;
   logic              in_ready;
   logic              accept;
   logic              s1_is_arith;
   logic [DATA_W-1:0] s1_res;
   logic [DATA_W-1:0] opnd_a;
   logic [DATA_W-1:0] opnd_b;

   always_comb begin
      s2_adv      = !s2_valid_q || OUT_READY;
      s1_adv      = s1_valid_q && s2_adv;
      // S1 can take a new entry when it is empty or is emptying this cycle.
      in_ready    = !s1_valid_q || s2_adv;
      accept      = IN_VALID && in_ready;
      s1_is_arith = (ctrl_alu_q != 3'b000);
      // This is the value the S1 entry will commit. It is also the S1
      // forwarding source.
      s1_res      = s1_is_arith ? ALU_S : alu_b_q;
   end

`ifdef FWD_EN
   localparam logic [OP_W-1:0] OP_STORE = OP_W'(8'h08);

   logic s1_fwd_ok;
   logic s2_fwd_ok;

   // Check the youngest producer first. An S2 entry that retires in this
   // cycle is still a valid source, because OUT_RES holds it until the edge.
   function automatic logic [DATA_W-1:0] fwd_pick(
      input logic              is_reg,
      input logic [REG_W-1:0]  src,
      input logic [DATA_W-1:0] raw,
      input logic              s1_ok,
      input logic [REG_W-1:0]  s1_dst,
      input logic [DATA_W-1:0] s1_val,
      input logic              s2_ok,
      input logic [REG_W-1:0]  s2_dst,
      input logic [DATA_W-1:0] s2_val
   );
      logic [DATA_W-1:0] v;
      v = raw;
      if (is_reg) begin
         if (s1_ok && (s1_dst == src)) begin
            v = s1_val;
         end else if (s2_ok && (s2_dst == src)) begin
            v = s2_val;
         end
      end
      return v;
   endfunction

   always_comb begin
      s1_fwd_ok = s1_valid_q && (s1_op_q != OP_STORE);
      s2_fwd_ok = s2_valid_q && (out_op_q != OP_STORE);
      opnd_a    = fwd_pick(IN_A_REG, IN_SRC_A, IN_A,
                           s1_fwd_ok, s1_dst_q, s1_res,
                           s2_fwd_ok, out_dst_q, out_res_q);
      opnd_b    = fwd_pick(IN_B_REG, IN_SRC_B, IN_B,
                           s1_fwd_ok, s1_dst_q, s1_res,
                           s2_fwd_ok, out_dst_q, out_res_q);
   end
`else
   // Without forwarding, upstream inserts bubbles on hazards. The source
   // tags are not needed here.
   logic unused_fwd_inputs;

   always_comb begin
      opnd_a = IN_A;
      opnd_b = IN_B;
   end

   assign unused_fwd_inputs = ^{IN_SRC_A, IN_SRC_B, IN_A_REG, IN_B_REG};
`endif

   // ---------------------------------------------------------------- next state
   always_comb begin
      s1_valid_d = s1_valid_q;
      alu_a_d    = alu_a_q;
      alu_b_d    = alu_b_q;
      ctrl_alu_d = ctrl_alu_q;
      s1_op_d    = s1_op_q;
      s1_dst_d   = s1_dst_q;
      s2_valid_d = s2_valid_q;
      out_op_d   = out_op_q;
      out_dst_d  = out_dst_q;
      out_res_d  = out_res_q;
      flags_d    = flags_q;

      // S1 payload changes only on accept. The ALU inputs therefore stay
      // constant while the entry is stalled.
      if (accept) begin
         s1_valid_d = 1'b1;
         alu_a_d    = opnd_a;
         alu_b_d    = opnd_b;
         ctrl_alu_d = map_op(IN_OP);
         s1_op_d    = IN_OP;
         s1_dst_d   = IN_DST;
      end else if (s1_adv) begin
         s1_valid_d = 1'b0;
      end

      if (s1_adv) begin
         s2_valid_d = 1'b1;
         out_op_d   = s1_op_q;
         out_dst_d  = s1_dst_q;
         out_res_d  = s1_res;
         // FLAGS follows instructions as they enter S2, not as they retire.
         if (s1_is_arith) begin
            flags_d = {ALU_N, ALU_O, ALU_Z, ALU_C};
         end
      end else if (OUT_READY) begin
         s2_valid_d = 1'b0;
      end
   end

   // ---------------------------------------------------------------- registers
   always_ff @(posedge CLK) begin
      if (!RST) begin
         s1_valid_q <= 1'b0;
         alu_a_q    <= '0;
         alu_b_q    <= '0;
         ctrl_alu_q <= 3'b000;
         s1_op_q    <= '0;
         s1_dst_q   <= '0;
         s2_valid_q <= 1'b0;
         out_op_q   <= '0;
         out_dst_q  <= '0;
         out_res_q  <= '0;
         flags_q    <= 4'b0000;
      end else begin
         s1_valid_q <= s1_valid_d;
         alu_a_q    <= alu_a_d;
         alu_b_q    <= alu_b_d;
         ctrl_alu_q <= ctrl_alu_d;
         s1_op_q    <= s1_op_d;
         s1_dst_q   <= s1_dst_d;
         s2_valid_q <= s2_valid_d;
         out_op_q   <= out_op_d;
         out_dst_q  <= out_dst_d;
         out_res_q  <= out_res_d;
         flags_q    <= flags_d;
      end
   end

   // ---------------------------------------------------------------- outputs
   assign IN_READY  = in_ready;
   assign ALU_A     = alu_a_q;
   assign ALU_B     = alu_b_q;
   assign CTRL_ALU  = ctrl_alu_q;
   assign OUT_VALID = s2_valid_q;
   assign OUT_OP    = out_op_q;
   assign OUT_DST   = out_dst_q;
   assign OUT_RES   = out_res_q;
   assign FLAGS     = flags_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_stage
//
// Drives alu_issue_stage with an ALU stand-in. A scoreboard follows the
// instructions in flight as a FIFO and predicts, each cycle, the outputs
// that follow from the handshake rules. Directed scenarios pin the literal
// values. A randomized phase then follows.
// -----------------------------------------------------------------------------
module tb_alu_issue_stage;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_op;
   logic [3:0] in_dst;
   logic [7:0] in_a;
   logic [7:0] in_b;
   logic [3:0] in_src_a;
   logic [3:0] in_src_b;
   logic       in_a_reg;
   logic       in_b_reg;
   logic [7:0] alu_a;
   logic [7:0] alu_b;
   logic [2:0] ctrl_alu;
   logic [7:0] alu_s;
   logic       alu_n;
   logic       alu_o;
   logic       alu_z;
   logic       alu_c;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_op;
   logic [3:0] out_dst;
   logic [7:0] out_res;
   logic [3:0] flags;

   int checks = 0;
   int errors = 0;

   alu_issue_stage #(.DATA_W(8), .OP_W(8), .REG_W(4)) dut (
      .CLK(clk), .RST(rst),
      .IN_VALID(in_valid), .IN_READY(in_ready),
      .IN_OP(in_op), .IN_DST(in_dst), .IN_A(in_a), .IN_B(in_b),
      .IN_SRC_A(in_src_a), .IN_SRC_B(in_src_b),
      .IN_A_REG(in_a_reg), .IN_B_REG(in_b_reg),
      .ALU_A(alu_a), .ALU_B(alu_b), .CTRL_ALU(ctrl_alu),
      .ALU_S(alu_s), .ALU_N(alu_n), .ALU_O(alu_o), .ALU_Z(alu_z), .ALU_C(alu_c),
      .OUT_VALID(out_valid), .OUT_READY(out_ready),
      .OUT_OP(out_op), .OUT_DST(out_dst), .OUT_RES(out_res), .FLAGS(flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ALU stand-in. The return value is {S, N, O, Z, C}.
   function automatic logic [11:0] alu_f(input logic [2:0] c, input logic [7:0] a, input logic [7:0] b);
      logic [8:0]  w;
      logic [15:0] m;
      logic [7:0]  s;
      logic        o;
      logic        cy;
      w = '0; m = '0; s = '0; o = 1'b0; cy = 1'b0;
      case (c)
         3'b001: begin w = {1'b0, a} + {1'b0, b}; s = w[7:0]; cy = w[8];
                       o = (a[7] == b[7]) && (s[7] != a[7]); end
         3'b010: begin m = 16'(a) * 16'(b); s = m[7:0]; cy = |m[15:8]; o = cy; end
         3'b011: begin w = {1'b0, a} - {1'b0, b}; s = w[7:0]; cy = w[8];
                       o = (a[7] != b[7]) && (s[7] != a[7]); end
         3'b100: begin s = (b == 8'h00) ? 8'hFF : a / b; cy = (b == 8'h00); end
         default: s = 8'h00;
      endcase
      return {s, s[7], o, (s == 8'h00), cy};
   endfunction

   always_comb {alu_s, alu_n, alu_o, alu_z, alu_c} = alu_f(ctrl_alu, alu_a, alu_b);

   function automatic logic [2:0] ctrl_of(input logic [7:0] op);
      case (op)
         8'h01:   return 3'b001;
         8'h02:   return 3'b010;
         8'h03:   return 3'b011;
         8'h04:   return 3'b100;
         default: return 3'b000;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------- model
   typedef struct {
      logic [7:0] op;
      logic [3:0] dst;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] res;
      logic [3:0] flags;
      int         acc;
   } ent_t;

   ent_t q[$];
   logic [3:0] run_flags = 4'b0000;
   int edge_n   = 0;
   int last_ret = 0;

   // An entry enters S2 one edge after it is accepted. It may have to wait
   // for the edge at which its predecessor retires.
   function automatic bit head_visible(input int upto);
      int e;
      if (q.size() == 0) return 1'b0;
      e = (q[0].acc + 1 > last_ret) ? q[0].acc + 1 : last_ret;
      return (e <= upto);
   endfunction

   initial begin
      forever begin
         @(posedge clk);
         edge_n++;
         if (!rst) begin
            q.delete();
            run_flags = 4'b0000;
            last_ret  = edge_n;
         end else begin
            bit   v;
            bit   acc;
            ent_t e;
            v   = head_visible(edge_n - 1);
            acc = in_valid && ((q.size() < 2) || out_ready);
            if (acc) begin
               logic [11:0] r;
               e.op = in_op; e.dst = in_dst; e.a = in_a; e.b = in_b; e.acc = edge_n;
`ifdef FWD_EN
               // The youngest in-flight producer wins. STOREs are skipped.
               if (in_a_reg)
                  for (int i = q.size() - 1; i >= 0; i--)
                     if (q[i].op != 8'h08 && q[i].dst == in_src_a) begin e.a = q[i].res; break; end
               if (in_b_reg)
                  for (int i = q.size() - 1; i >= 0; i--)
                     if (q[i].op != 8'h08 && q[i].dst == in_src_b) begin e.b = q[i].res; break; end
`endif
               if (ctrl_of(e.op) != 3'b000) begin
                  r = alu_f(ctrl_of(e.op), e.a, e.b);
                  e.res = r[11:4];
                  run_flags = r[3:0];
               end else begin
                  e.res = e.b;
               end
               e.flags = run_flags;
            end
            if (v && out_ready) begin
               void'(q.pop_front());
               last_ret = edge_n;
            end
            if (acc) q.push_back(e);
         end
      end
   end

   // ---------------------------------------------------------------- compare
   always @(negedge clk) begin
      if (rst) begin
         bit v;
         v = head_visible(edge_n);
         chk("out_valid", out_valid, v);
         chk("in_ready", in_ready, (q.size() < 2) || out_ready);
         if (v) begin
            chk("out_op", out_op, q[0].op);
            chk("out_dst", out_dst, q[0].dst);
            chk("out_res", out_res, q[0].res);
            chk("flags", flags, q[0].flags);
         end else if (q.size() == 0) begin
            chk("flags_idle", flags, run_flags);
         end
         if (q.size() == 2 || (q.size() == 1 && !v)) begin
            ent_t s;
            s = q[q.size() - 1];
            chk("alu_a", alu_a, s.a);
            chk("alu_b", alu_b, s.b);
            chk("ctrl_alu", ctrl_alu, ctrl_of(s.op));
         end
      end
   end

   // ---------------------------------------------------------------- driver
   task automatic set_in(input logic [7:0] op, input logic [3:0] dst, input logic [7:0] a,
                         input logic [7:0] b, input logic [3:0] sa, input logic [3:0] sb,
                         input logic ar, input logic br);
      in_valid = 1'b1; in_op = op; in_dst = dst; in_a = a; in_b = b;
      in_src_a = sa; in_src_b = sb; in_a_reg = ar; in_b_reg = br;
   endtask

   // Called just after a rising edge. Returns just after the accepting edge,
   // with IN_VALID dropped.
   task automatic issue(input logic [7:0] op, input logic [3:0] dst, input logic [7:0] a,
                        input logic [7:0] b, input logic [3:0] sa, input logic [3:0] sb,
                        input logic ar, input logic br);
      bit got;
      bit r;
      got = 1'b0;
      set_in(op, dst, a, b, sa, sb, ar, br);
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge clk); r = in_ready;
         @(posedge clk); got = r;
      end
      chk("issue_accept", got, 1'b1);
      #1 in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; out_ready = 1'b1;
      in_valid = 1'b0; in_op = '0; in_dst = '0; in_a = '0; in_b = '0;
      in_src_a = '0; in_src_b = '0; in_a_reg = 1'b0; in_b_reg = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_flags", flags, 4'b0000);
      chk("rst_ctrl_alu", ctrl_alu, 3'b000);
      chk("rst_alu_a", alu_a, 8'h00);
      chk("rst_out_res", out_res, 8'h00);
      chk("rst_out_dst", out_dst, 4'h0);
      @(posedge clk); #1 rst = 1'b1;
      @(negedge clk);
      chk("ready_after_rst", in_ready, 1'b1);
      @(posedge clk); #1;

      // Test 1: ADD 5+3.
      issue(8'h01, 4'h3, 8'h05, 8'h03, 4'h0, 4'h0, 1'b0, 1'b0);
      @(negedge clk);
      chk("t1_not_yet", out_valid, 1'b0);
      @(negedge clk);
      chk("t1_valid", out_valid, 1'b1);
      chk("t1_res", out_res, 8'h08);
      chk("t1_flags", flags, 4'b0000);
      idle(3);

      // Test 2: SOU 3-5, then AFC 0x2A. FLAGS must survive the AFC.
      issue(8'h03, 4'h4, 8'h03, 8'h05, 4'h0, 4'h0, 1'b0, 1'b0);
      issue(8'h06, 4'h5, 8'h77, 8'h2A, 4'h0, 4'h0, 1'b0, 1'b0);
      @(negedge clk);
      chk("t2_sou_res", out_res, 8'hFE);
      chk("t2_sou_n", flags[3], 1'b1);
      chk("t2_sou_flags", flags, 4'b1001);
      @(negedge clk);
      chk("t2_afc_res", out_res, 8'h2A);
      chk("t2_afc_flags", flags, 4'b1001);
      idle(3);

      // Test 3: backpressure with three offered instructions.
      out_ready = 1'b0;
      issue(8'h01, 4'h1, 8'h07, 8'h09, 4'h0, 4'h0, 1'b0, 1'b0);
      issue(8'h02, 4'h2, 8'h03, 8'h04, 4'h0, 4'h0, 1'b0, 1'b0);
      set_in(8'h04, 4'h3, 8'h14, 8'h03, 4'h0, 4'h0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t3_stall_ready", in_ready, 1'b0);
         chk("t3_stall_ctrl", ctrl_alu, 3'b010);
      end
      @(posedge clk); #1 out_ready = 1'b1;
      @(negedge clk);
      chk("t3_ret0_op", out_op, 8'h01);
      chk("t3_ret0_res", out_res, 8'h10);
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk);
      chk("t3_ret1_valid", out_valid, 1'b1);
      chk("t3_ret1_op", out_op, 8'h02);
      @(negedge clk);
      chk("t3_ret2_valid", out_valid, 1'b1);
      chk("t3_ret2_op", out_op, 8'h04);
      chk("t3_ret2_res", out_res, 8'h06);
      idle(3);

      // Test 4: reset with both stages full and a third offered.
      out_ready = 1'b0;
      issue(8'h03, 4'h1, 8'h03, 8'h05, 4'h0, 4'h0, 1'b0, 1'b0);
      issue(8'h01, 4'h2, 8'h01, 8'h01, 4'h0, 4'h0, 1'b0, 1'b0);
      set_in(8'h02, 4'h3, 8'h02, 8'h02, 4'h0, 4'h0, 1'b0, 1'b0);
      @(negedge clk);
      chk("t4_pre_flags", flags, 4'b1001);
      @(posedge clk); #1 out_ready = 1'b1; rst = 1'b0;
      @(posedge clk); #1 rst = 1'b1; in_valid = 1'b0;
      @(negedge clk);
      chk("t4_out_valid", out_valid, 1'b0);
      chk("t4_flags", flags, 4'b0000);
      chk("t4_ctrl", ctrl_alu, 3'b000);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t4_no_retire", out_valid, 1'b0);
      end
      @(posedge clk); #1;

      // Test 5: AFC r1=0x10, then ADD r2=r1+r1 with stale operand values.
      issue(8'h06, 4'h1, 8'h00, 8'h10, 4'h0, 4'h0, 1'b0, 1'b0);
      issue(8'h01, 4'h2, 8'h00, 8'h00, 4'h1, 4'h1, 1'b1, 1'b1);
      @(negedge clk);
      @(negedge clk);
      chk("t5_op", out_op, 8'h01);
`ifdef FWD_EN
      chk("t5_res", out_res, 8'h20);
`else
      chk("t5_res", out_res, 8'h00);
`endif
      idle(3);

      // Test 6: MUL overflow case, 0x10*0x10.
      issue(8'h02, 4'h6, 8'h10, 8'h10, 4'h0, 4'h0, 1'b0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      chk("t6_res", out_res, 8'h00);
      chk("t6_flags", flags, 4'b0111);
      idle(3);

      // Random phase.
      for (int i = 0; i < 600; i++) begin
         int sel;
         sel = $urandom_range(0, 9);
         in_valid = ($urandom_range(0, 99) < 70);
         in_op    = (sel == 9) ? 8'($urandom) : 8'(sel);
         in_dst   = 4'($urandom_range(0, 3));
         in_a     = 8'($urandom);
         in_b     = 8'($urandom);
         in_src_a = 4'($urandom_range(0, 3));
         in_src_b = 4'($urandom_range(0, 3));
         in_a_reg = 1'($urandom);
         in_b_reg = 1'($urandom);
         out_ready = ($urandom_range(0, 99) < 65);
         rst = ($urandom_range(0, 199) != 0);
         @(posedge clk); #1;
      end
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      idle(6);
      chk("drain_empty", out_valid, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
